icache_assoc: RTL and testbench

- Parametrised successor to the direct-mapped nibble-fill instruction cache.
- Set-associative: 1 or 2 ways. Per-set LRU replacement. Configurable set count, line length and fetch width (16/32).
- Internal fill FSM latches the miss address, so the CPU fetch address may move during a fill.
- Sits between the CPU fetch stage and the quad-SPI flash reader; the reader streams 4-bit nibbles on wstrobe_d.

---
 rtl/icache_assoc_if.sv | 40 ++++
 rtl/icache_assoc.sv | 216 +++++++++++++++++++++
 tb/tb_icache_assoc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_if.sv
// Fetch/fill bus of icache_assoc: CPU fetch side plus the quad-SPI nibble stream.
// Counter signals exist only when ICACHE_STATS_EN is defined.
interface icache_assoc_if #(
    parameter int PA          = 22,
    parameter int RV          = 16,
    parameter int LINE_LENGTH = 4
);
    logic [PA-1:1]                   paddr;
    logic                            req;
    logic [3:0]                      dread;
    logic                            wstrobe_d;
    logic                            flush_all;
    logic                            hit;
    logic                            pull;
    logic [PA-1:$clog2(LINE_LENGTH)] tag;
    logic [RV-1:0]                   rdata;
    logic                            busy;
`ifdef ICACHE_STATS_EN
    logic [15:0]                     hit_count;
    logic [15:0]                     miss_count;

    modport master (
        output paddr, req, dread, wstrobe_d, flush_all,
        input  hit, pull, tag, rdata, busy, hit_count, miss_count
    );
    modport slave (
        input  paddr, req, dread, wstrobe_d, flush_all,
        output hit, pull, tag, rdata, busy, hit_count, miss_count
    );
`else
    modport master (
        output paddr, req, dread, wstrobe_d, flush_all,
        input  hit, pull, tag, rdata, busy
    );
    modport slave (
        input  paddr, req, dread, wstrobe_d, flush_all,
        output hit, pull, tag, rdata, busy
    );
`endif
endinterface

// File: rtl/icache_assoc.sv
// 1/2-way set-associative instruction cache filled by a nibble stream from a flash reader.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_assoc #(
    parameter int LINE_LENGTH = 4,
    parameter int NSETS       = 4,
    parameter int WAYS        = 2,
    parameter int RV          = 16,
    parameter int PA          = 22
) (
    input  logic          clk,
    input  logic          reset,
    icache_assoc_if.slave bus
);

    localparam int OFFB      = $clog2(LINE_LENGTH);
    localparam int SETB      = $clog2(NSETS);
    localparam int TAGB      = PA - OFFB - SETB;
    localparam int LINEB     = LINE_LENGTH * 8;
    localparam int NIBS      = LINE_LENGTH * 2;
    localparam int CNTB      = $clog2(NIBS);
    localparam int HWB       = OFFB - 1;
    localparam int SEL_SHIFT = (RV == 32) ? 1 : 0;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [TAGB-1:0]             r_tag_arr  [NSETS][WAYS];
    logic [LINEB-1:0]            r_data_arr [NSETS][WAYS];
    logic [NSETS-1:0][WAYS-1:0]  r_valid;
    logic [NSETS-1:0]            r_lru;

    logic [TAGB-1:0]             r_fill_tag;
    logic [SETB-1:0]             r_fill_set;
    logic                        r_fill_way;
    logic [CNTB-1:0]             r_offset;

    logic [SETB-1:0]             w_set;
    logic [TAGB-1:0]             w_ptag;
    logic [HWB-1:0]              w_hw;
    logic [HWB-1:0]              w_sel;
    logic                        w_hit_any;
    logic                        w_hit_way;
    logic                        w_hit;
    logic                        w_victim;
    logic [LINEB-1:0]            w_line;
    logic [CNTB-1:0]             w_nib;
    logic                        w_last;
    logic                        w_start;
    logic                        w_wr;
    logic                        w_done;
    logic                        w_busy;
    logic                        w_pull;
    logic [PA-OFFB-1:0]          w_tag;

    assign w_set  = bus.paddr[OFFB+SETB-1:OFFB];
    assign w_ptag = bus.paddr[PA-1:OFFB+SETB];
    assign w_hw   = bus.paddr[OFFB-1:1];

    // The way currently being filled never hits, even if its stale tag matches.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit_any && r_valid[w_set][w] && (r_tag_arr[w_set][w] == w_ptag) &&
                !(r_state == ST_FILL && w_set == r_fill_set && 1'(w) == r_fill_way)) begin
                w_hit_any = 1'b1;
                w_hit_way = 1'(w);
            end
        end
    end

    assign w_hit  = bus.req && w_hit_any;
    assign w_line = r_data_arr[w_set][w_hit_way];
    assign w_sel  = w_hw >> SEL_SHIFT;

    // Invalid way first (way 0 preferred), otherwise the LRU bit names the victim.
    always_comb begin
        w_victim = 1'b0;
        if (WAYS == 2) begin
            if (!r_valid[w_set][0]) begin
                w_victim = 1'b0;
            end else if (!r_valid[w_set][WAYS-1]) begin
                w_victim = 1'b1;
            end else begin
                w_victim = r_lru[w_set];
            end
        end
    end

    // High nibble of each byte arrives first, hence the xor on the nibble index.
    assign w_nib  = r_offset ^ CNTB'(1);
    assign w_last = (r_offset == CNTB'(NIBS - 1));

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_pull      = 1'b0;
        w_tag       = bus.paddr[PA-1:OFFB];
        w_start     = 1'b0;
        w_wr        = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_pull = bus.req && !w_hit;
                if (bus.req && !w_hit && !bus.flush_all) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_busy = 1'b1;
                w_pull = 1'b1;
                w_tag  = {r_fill_tag, r_fill_set};
                if (bus.flush_all) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.wstrobe_d) begin
                    w_wr = 1'b1;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; later statements win on conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_valid    <= '0;
            r_lru      <= '0;
            r_offset   <= '0;
            r_fill_tag <= '0;
            r_fill_set <= '0;
            r_fill_way <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.flush_all) begin
                r_valid  <= '0;
                r_lru    <= '0;
                r_offset <= '0;
            end else begin
                if (w_hit && WAYS == 2) begin
                    r_lru[w_set] <= ~w_hit_way;
                end
                if (w_start) begin
                    r_fill_tag               <= w_ptag;
                    r_fill_set               <= w_set;
                    r_fill_way               <= w_victim;
                    r_valid[w_set][w_victim] <= 1'b0;
                    r_offset                 <= '0;
                end
                if (w_wr) begin
                    // Completion wraps the counter back to zero.
                    r_offset <= r_offset + CNTB'(1);
                    if (w_done) begin
                        r_valid[r_fill_set][r_fill_way] <= 1'b1;
                        if (WAYS == 2) begin
                            r_lru[r_fill_set] <= ~r_fill_way;
                        end
                    end
                end
            end
        end
    end

    // NOTE: data and tag arrays are deliberately not reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_data_arr[r_fill_set][r_fill_way][int'(w_nib)*4 +: 4] <= bus.dread;
        end
        if (w_done) begin
            r_tag_arr[r_fill_set][r_fill_way] <= r_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (bus.flush_all) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && r_hit_count != 16'hFFFF) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_start && r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
`endif

    assign bus.hit   = w_hit;
    assign bus.pull  = w_pull;
    assign bus.busy  = w_busy;
    assign bus.tag   = w_tag;
    assign bus.rdata = w_line[int'(w_sel)*RV +: RV];

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (2 ways, 4 sets, 4-byte lines, 16-bit fetch).
// A nibble stream 0xAABBCCDD is sent high nibble first: bytes AA,BB,CC,DD -> halfwords 0xBBAA, 0xDDCC.
module tb_icache_assoc;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    icache_assoc_if #(.PA(22), .RV(16), .LINE_LENGTH(4)) bus ();

    icache_assoc #(
        .LINE_LENGTH(4),
        .NSETS      (4),
        .WAYS       (2),
        .RV         (16),
        .PA         (22)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [21:0] a);
        bus.req   = 1'b1;
        bus.paddr = a[21:1];
        #1;
    endtask

    task automatic strobe(input logic [3:0] n);
        bus.wstrobe_d = 1'b1;
        bus.dread     = n;
        tick();
        bus.wstrobe_d = 1'b0;
        bus.dread     = 4'h0;
    endtask

    task automatic send(input logic [31:0] s, input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            strobe(s[31-4*i -: 4]);
        end
    endtask

    task automatic fill(input logic [21:0] a, input logic [31:0] s);
        peek(a);
        tick();
        bus.req = 1'b0;
        send(s, 0, 7);
        check("fill_busy_before_last", bus.busy, 1);
        send(s, 7, 1);
        check("fill_busy_after_last", bus.busy, 0);
    endtask

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.req       = 1'b0;
        bus.paddr     = '0;
        bus.dread     = 4'h0;
        bus.wstrobe_d = 1'b0;
        bus.flush_all = 1'b0;
        tick();
        tick();
        check("rst_hit", bus.hit, 0);
        check("rst_pull", bus.pull, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();

        // Basic miss, fill and hit on 0x100.
        peek(22'h000100);
        check("a_miss_hit", bus.hit, 0);
        check("a_miss_pull", bus.pull, 1);
        check("a_miss_tag", bus.tag, 64'h40);
        check("a_idle_busy", bus.busy, 0);
        tick();
        check("a_fill_busy", bus.busy, 1);
        check("a_fill_pull", bus.pull, 1);
        bus.req = 1'b0;
        #1;
        check("a_fill_tag_noreq", bus.tag, 64'h40);
        check("a_fill_pull_noreq", bus.pull, 1);
        send(32'h10325476, 0, 8);
        check("a_done_busy", bus.busy, 0);
        peek(22'h000100);
        check("a_hit", bus.hit, 1);
        check("a_rdata_lo", bus.rdata, 16'h3210);
        peek(22'h000102);
        check("a_rdata_hi", bus.rdata, 16'h7654);
        tick();
        bus.req = 1'b0;

        // Hit-under-fill while 0x004 streams in.
        peek(22'h000004);
        check("b_miss_tag", bus.tag, 64'h1);
        tick();
        bus.req = 1'b0;
        send(32'h11223344, 0, 3);
        peek(22'h000100);
        check("b_huf_hit", bus.hit, 1);
        check("b_huf_rdata", bus.rdata, 16'h3210);
        check("b_huf_tag", bus.tag, 64'h1);
        check("b_huf_busy", bus.busy, 1);
        peek(22'h000104);
        check("b_other_miss", bus.hit, 0);
        check("b_other_tag", bus.tag, 64'h1);
        bus.req = 1'b0;
        send(32'h11223344, 3, 5);
        check("b_done_busy", bus.busy, 0);
        peek(22'h000004);
        check("b_line_hit", bus.hit, 1);
        check("b_line_lo", bus.rdata, 16'h2211);
        peek(22'h000006);
        check("b_line_hi", bus.rdata, 16'h4433);
        bus.req = 1'b0;

        // Flush after three strobes of a fill of 0x008.
        peek(22'h000008);
        check("c_miss_tag", bus.tag, 64'h2);
        tick();
        bus.req = 1'b0;
        send(32'h55667788, 0, 3);
        bus.flush_all = 1'b1;
        tick();
        bus.flush_all = 1'b0;
        check("c_flush_busy", bus.busy, 0);
        peek(22'h000100);
        check("c_flushed_100", bus.hit, 0);
        check("c_flushed_pull", bus.pull, 1);
        peek(22'h000004);
        check("c_flushed_004", bus.hit, 0);
        bus.req = 1'b0;
        #1;
        check("c_idle_pull", bus.pull, 0);
        send(32'h55667788, 3, 5);
        check("c_stray_busy", bus.busy, 0);
        check("c_stray_pull", bus.pull, 0);
        fill(22'h000008, 32'h55667788);
        peek(22'h000008);
        check("c_refill_hit", bus.hit, 1);
        check("c_refill_rdata", bus.rdata, 16'h6655);
        bus.req = 1'b0;

        // LRU replacement in set 0.
        fill(22'h000000, 32'hA1B2C3D4);
        fill(22'h000010, 32'h0F1E2D3C);
        peek(22'h000000);
        check("d_hit_000", bus.hit, 1);
        check("d_rdata_000", bus.rdata, 16'hB2A1);
        tick();
        peek(22'h000010);
        check("d_hit_010", bus.hit, 1);
        check("d_rdata_010", bus.rdata, 16'h1E0F);
        tick();
        peek(22'h000000);
        tick();
        bus.req = 1'b0;
        peek(22'h000020);
        check("d_miss_020_tag", bus.tag, 64'h8);
        bus.req = 1'b0;
        fill(22'h000020, 32'h99AABBCC);
        peek(22'h000000);
        check("d_keep_000", bus.hit, 1);
        check("d_keep_rdata", bus.rdata, 16'hB2A1);
        peek(22'h000020);
        check("d_new_020", bus.hit, 1);
        check("d_new_rdata", bus.rdata, 16'hAA99);
        peek(22'h000010);
        check("d_evicted_010", bus.hit, 0);
        bus.req = 1'b0;

        // Asynchronous reset in the middle of a fill.
        peek(22'h000010);
        tick();
        bus.req = 1'b0;
        send(32'h0F1E2D3C, 0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_busy", bus.busy, 0);
        check("e_rst_pull", bus.pull, 0);
        tick();
        rst_n = 1'b1;
        #1;
        peek(22'h000000);
        check("e_rst_cleared", bus.hit, 0);
        peek(22'h000010);
        check("e_refetch_miss", bus.hit, 0);
        check("e_refetch_tag", bus.tag, 64'h4);
        bus.req = 1'b0;
        fill(22'h000010, 32'h0F1E2D3C);
        peek(22'h000010);
        check("e_refill_hit", bus.hit, 1);
        check("e_refill_lo", bus.rdata, 16'h1E0F);
        peek(22'h000012);
        check("e_refill_hi", bus.rdata, 16'h3C2D);
        bus.req = 1'b0;

`ifdef ICACHE_STATS_EN
        bus.flush_all = 1'b1;
        tick();
        bus.flush_all = 1'b0;
        check("s_flush_hits", bus.hit_count, 0);
        check("s_flush_miss", bus.miss_count, 0);
        fill(22'h000000, 32'hA1B2C3D4);
        fill(22'h000004, 32'h11223344);
        peek(22'h000000);
        tick();
        peek(22'h000004);
        tick();
        peek(22'h000000);
        tick();
        bus.req = 1'b0;
        check("s_hit_count", bus.hit_count, 3);
        check("s_miss_count", bus.miss_count, 2);
        bus.flush_all = 1'b1;
        tick();
        bus.flush_all = 1'b0;
        check("s_clear_hits", bus.hit_count, 0);
        check("s_clear_miss", bus.miss_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
